// File: rtl/uart_pkg.sv
// Shared constants for the 8N1 UART pair: default bit period, frame size, FSM state codes.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package uart_pkg;

  // 128 clocks per bit gives 115200 baud from a 14.7456 MHz clock.
  localparam int CLKS_PER_BIT_DEFAULT = 128;

  // Data bits per frame, and the bit index at which the data phase ends.
  localparam int         FRAME_DATA_BITS = 8;
  localparam logic [2:0] LAST_DATA_BIT   = 3'(FRAME_DATA_BITS - 1);

  // Receiver states.
  localparam logic [2:0] RX_IDLE      = 3'd0;
  localparam logic [2:0] RX_START     = 3'd1;
  localparam logic [2:0] RX_DATA      = 3'd2;
  localparam logic [2:0] RX_STOP      = 3'd3;
  localparam logic [2:0] RX_WAIT_HIGH = 3'd4;

  // Transmitter states.
  localparam logic [1:0] TX_IDLE  = 2'd0;
  localparam logic [1:0] TX_START = 2'd1;
  localparam logic [1:0] TX_DATA  = 2'd2;
  localparam logic [1:0] TX_STOP  = 2'd3;

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period down-counter: load with a full or half bit, pulses expire when it reaches zero.
// Latency: expire is high in the CLKS_PER_BIT-th (or CLKS_PER_BIT/2-th) cycle after load.
// Backpressure: none; after expiring it reloads a full bit by itself and keeps running.
//
// Ports:
//   clk, rst_n : clock, synchronous active-low reset
//   load       : restart the count this cycle (wins over everything else)
//   half       : with load, count CLKS_PER_BIT/2 instead of CLKS_PER_BIT
//   expire     : one-cycle pulse at the end of each counted period
module uart_bit_timer #(
  parameter int CLKS_PER_BIT = 128
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic half,
  output logic expire
);

  localparam int            CW      = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] FULL_LD = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LD = CW'(CLKS_PER_BIT / 2 - 1);

  logic [CW-1:0] cnt;
  logic          active;

  assign expire = active && (cnt == '0);

  // Auto-reload on expiry keeps successive bits exactly CLKS_PER_BIT apart
  // without the FSMs having to re-arm the timer every bit.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt    <= '0;
      active <= 1'b0;
    end else if (load) begin
      cnt    <= half ? HALF_LD : FULL_LD;
      active <= 1'b1;
    end else if (expire) begin
      cnt <= FULL_LD;
    end else if (active) begin
      cnt <= cnt - CW'(1);
    end
  end

endmodule

// File: rtl/uart_rx_tx.sv
// 8N1 UART receiver and transmitter sharing one clock and reset.
// Latency: rx_done 3 cycles after the stop-bit mid-point; tx goes low the cycle after an accepted tx_go.
// Backpressure: tx_go is ignored while tx_busy; the receiver never stalls (rx_byte is overwritten per good frame).
//
// Ports:
//   clk, rst_n   : clock, synchronous active-low reset
//   rx           : asynchronous serial input, idles high
//   rx_done      : one-cycle pulse, rx_byte valid from this cycle
//   rx_byte      : last correctly framed byte, held until the next good frame
//   rx_frame_err : one-cycle pulse when the stop bit is sampled low
//   tx_data      : byte to send, captured on an accepted tx_go
//   tx_go        : start request, accepted only while tx_busy is low
//   tx_busy      : high while a frame is on the wire
//   tx           : serial output, idles high
module uart_rx_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic       rx_done,
  output logic [7:0] rx_byte,
  output logic       rx_frame_err,
  input  logic [7:0] tx_data,
  input  logic       tx_go,
  output logic       tx_busy,
  output logic       tx
);

  // ------------------------------------------------------------------
  // Receiver
  // ------------------------------------------------------------------
  logic       rx_meta;
  logic       rx_sync;
  logic [2:0] rx_state;
  logic [2:0] rx_bit_cnt;
  logic [7:0] rx_shift;
  logic       rx_tmr_load;
  logic       rx_tmr_exp;

  // Synchroniser resets to the idle (high) level so reset never looks like a start bit.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
    end
  end

  // Arm a half-bit wait on the start edge; the timer then free-runs in
  // full bits, so every later expiry lands on a bit mid-point.
  assign rx_tmr_load = (rx_state == RX_IDLE) && !rx_sync;

  uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (rx_tmr_load),
    .half   (1'b1),
    .expire (rx_tmr_exp)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_state     <= RX_IDLE;
      rx_bit_cnt   <= '0;
      rx_shift     <= '0;
      rx_byte      <= '0;
      rx_done      <= 1'b0;
      rx_frame_err <= 1'b0;
    end else begin
      rx_done      <= 1'b0;
      rx_frame_err <= 1'b0;
      case (rx_state)
        RX_IDLE: begin
          if (!rx_sync) rx_state <= RX_START;
        end
        RX_START: begin
          if (rx_tmr_exp) begin
            if (!rx_sync) begin
              rx_state   <= RX_DATA;
              rx_bit_cnt <= '0;
            end else begin
              // Line was back high at mid-start: a glitch, not a frame.
              rx_state <= RX_IDLE;
            end
          end
        end
        RX_DATA: begin
          if (rx_tmr_exp) begin
            rx_shift   <= {rx_sync, rx_shift[7:1]};
            rx_bit_cnt <= rx_bit_cnt + 3'd1;
            if (rx_bit_cnt == LAST_DATA_BIT) rx_state <= RX_STOP;
          end
        end
        RX_STOP: begin
          if (rx_tmr_exp) begin
            if (rx_sync) begin
              rx_byte  <= rx_shift;
              rx_done  <= 1'b1;
              rx_state <= RX_IDLE;
            end else begin
              rx_frame_err <= 1'b1;
              rx_state     <= RX_WAIT_HIGH;
            end
          end
        end
        RX_WAIT_HIGH: begin
          // A held-low line (break) must not be decoded as a stream of zero frames.
          if (rx_sync) rx_state <= RX_IDLE;
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

  // ------------------------------------------------------------------
  // Transmitter
  // ------------------------------------------------------------------
  logic [1:0] tx_state;
  logic [2:0] tx_bit_cnt;
  logic [7:0] tx_shift;
  logic       tx_accept;
  logic       tx_tmr_exp;

  assign tx_accept = (tx_state == TX_IDLE) && tx_go;
  assign tx_busy   = (tx_state != TX_IDLE);

  uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (tx_accept),
    .half   (1'b0),
    .expire (tx_tmr_exp)
  );

  // tx is registered and changes only on timer expiry, so each bit is
  // held for exactly CLKS_PER_BIT cycles.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tx_state   <= TX_IDLE;
      tx_bit_cnt <= '0;
      tx_shift   <= '0;
      tx         <= 1'b1;
    end else begin
      case (tx_state)
        TX_IDLE: begin
          if (tx_go) begin
            tx_state <= TX_START;
            tx_shift <= tx_data;
            tx       <= 1'b0;
          end
        end
        TX_START: begin
          if (tx_tmr_exp) begin
            tx_state   <= TX_DATA;
            tx         <= tx_shift[0];
            tx_shift   <= {1'b0, tx_shift[7:1]};
            tx_bit_cnt <= '0;
          end
        end
        TX_DATA: begin
          if (tx_tmr_exp) begin
            if (tx_bit_cnt == LAST_DATA_BIT) begin
              tx_state <= TX_STOP;
              tx       <= 1'b1;
            end else begin
              tx         <= tx_shift[0];
              tx_shift   <= {1'b0, tx_shift[7:1]};
              tx_bit_cnt <= tx_bit_cnt + 3'd1;
            end
          end
        end
        TX_STOP: begin
          if (tx_tmr_exp) tx_state <= TX_IDLE;
        end
        default: tx_state <= TX_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_tx.sv
// Self-checking bench for uart_rx_tx with CLKS_PER_BIT = 8.
// A frame-level model predicts tx/tx_busy every cycle and a queue of expected RX events.
// rx is driven either by the bench or looped back from tx.
module tb_uart_rx_tx;

  localparam int CPB       = 8;
  localparam int FRAME_CYC = 10 * CPB;
  localparam int RX_LAT    = (19 * CPB) / 2 + 3;
  localparam int TOL       = 2;

  typedef struct {
    bit         err;
    logic [7:0] b;
    int         due;
  } ev_t;

  logic       clk;
  logic       rst_n;
  logic       rx_drv;
  logic       loop_en;
  logic       rx_line;
  logic       rx_done;
  logic [7:0] rx_byte;
  logic       rx_frame_err;
  logic [7:0] tx_data;
  logic       tx_go;
  logic       tx_busy;
  logic       tx;

  assign rx_line = loop_en ? tx : rx_drv;

  uart_rx_tx #(.CLKS_PER_BIT(CPB)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .rx           (rx_line),
    .rx_done      (rx_done),
    .rx_byte      (rx_byte),
    .rx_frame_err (rx_frame_err),
    .tx_data      (tx_data),
    .tx_go        (tx_go),
    .tx_busy      (tx_busy),
    .tx           (tx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         n_cmp = 0;
  int         n_err = 0;
  int         cyc = 0;
  int         m_pos = -1;
  logic [9:0] m_frame = 10'h3FF;
  logic [7:0] m_rx_byte = 8'h00;
  ev_t        rxq[$];
  int         n_done = 0;
  int         n_ferr = 0;
  bit         chk_on = 1'b0;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Frame-level model: a frame is 10 bits of CPB cycles each, starting the
  // cycle after an accepted request; requests during a frame are dropped.
  always @(posedge clk) begin
    cyc++;
    if (!rst_n) begin
      m_pos     = -1;
      m_rx_byte = 8'h00;
      rxq.delete();
    end else if (m_pos >= 0) begin
      m_pos++;
      if (m_pos == FRAME_CYC) m_pos = -1;
    end else if (tx_go) begin
      m_frame = {1'b1, tx_data, 1'b0};
      m_pos   = 0;
      if (loop_en) rxq.push_back('{err: 1'b0, b: tx_data, due: cyc + RX_LAT});
    end
  end

  // Per-cycle compare against the model.
  always @(negedge clk) begin
    if (chk_on) begin
      logic exp_busy;
      logic exp_tx;
      ev_t  ev;
      exp_busy = (m_pos >= 0);
      exp_tx   = exp_busy ? m_frame[m_pos / CPB] : 1'b1;
      cmp("tx", tx, exp_tx);
      cmp("tx_busy", tx_busy, exp_busy);
      if (rx_done || rx_frame_err) begin
        if (rx_done) n_done++;
        if (rx_frame_err) n_ferr++;
        if (rxq.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL rx_unexpected_pulse: got done=%0b err=%0b, expected no pulse (cycle %0d)",
                   rx_done, rx_frame_err, cyc);
        end else begin
          ev = rxq.pop_front();
          cmp("rx_kind", {30'd0, rx_frame_err, rx_done}, ev.err ? 32'd2 : 32'd1);
          cmp("rx_pulse_time", cyc, (cyc >= ev.due - TOL && cyc <= ev.due + TOL) ? cyc : ev.due);
          if (!ev.err) m_rx_byte = ev.b;
        end
      end else if (rxq.size() > 0 && cyc > rxq[0].due + TOL) begin
        ev = rxq.pop_front();
        n_cmp++;
        n_err++;
        $display("FAIL rx_missing_pulse: got none by cycle %0d, expected %s for %0h at %0d",
                 cyc, ev.err ? "frame_err" : "done", ev.b, ev.due);
        if (!ev.err) m_rx_byte = ev.b;
      end
      cmp("rx_byte", rx_byte, m_rx_byte);
    end
  end

  // All tasks are entered just after a falling clock edge.
  task automatic wait_idle();
    int i;
    for (i = 0; i < 3000; i++) begin
      if (rxq.size() == 0 && m_pos < 0) break;
      @(negedge clk);
    end
    if (i >= 3000) begin
      n_cmp++;
      n_err++;
      $display("FAIL wait_idle: got still busy after 3000 cycles, expected idle");
    end
    repeat (5) @(negedge clk);
  endtask

  task automatic send_rx(input logic [7:0] b, input bit stop_bit);
    logic [9:0] bits;
    bits = {stop_bit, b, 1'b0};
    rxq.push_back('{err: ~stop_bit, b: b, due: cyc + RX_LAT});
    for (int i = 0; i < 10; i++) begin
      rx_drv = bits[i];
      repeat (CPB) @(negedge clk);
    end
  endtask

  task automatic pulse_go(input logic [7:0] b);
    tx_data = b;
    tx_go   = 1'b1;
    @(negedge clk);
    tx_go   = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish by 500000 time units, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int   d_done;
    int   d_ferr;
    int   busy_cnt;
    logic cap_tx[0:81];
    logic cap_busy[0:81];

    rst_n   = 1'b0;
    rx_drv  = 1'b1;
    loop_en = 1'b0;
    tx_go   = 1'b0;
    tx_data = 8'h00;
    repeat (3) @(negedge clk);
    chk_on = 1'b1;

    // Reset state.
    cmp("rst_tx", tx, 1'b1);
    cmp("rst_tx_busy", tx_busy, 1'b0);
    cmp("rst_rx_done", rx_done, 1'b0);
    cmp("rst_rx_frame_err", rx_frame_err, 1'b0);
    cmp("rst_rx_byte", rx_byte, 8'h00);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Loopback 0xA5.
    loop_en = 1'b1;
    d_done  = n_done;
    pulse_go(8'hA5);
    busy_cnt = 0;
    for (int k = 0; k < 120; k++) begin
      if (tx_busy) busy_cnt++;
      @(negedge clk);
    end
    cmp("a5_busy_cycles", busy_cnt, 80);
    wait_idle();
    cmp("a5_done_count", n_done - d_done, 1);
    cmp("a5_rx_byte", rx_byte, 8'hA5);

    // Bit order with 0x01: capture the waveform from the first busy cycle.
    pulse_go(8'h01);
    for (int k = 1; k <= 81; k++) begin
      cap_tx[k]   = tx;
      cap_busy[k] = tx_busy;
      @(negedge clk);
    end
    cmp("b01_start_first", cap_tx[1], 1'b0);
    cmp("b01_start_last", cap_tx[8], 1'b0);
    cmp("b01_d0_first", cap_tx[9], 1'b1);
    cmp("b01_d0_last", cap_tx[16], 1'b1);
    cmp("b01_d1_first", cap_tx[17], 1'b0);
    cmp("b01_d7_last", cap_tx[72], 1'b0);
    cmp("b01_stop_first", cap_tx[73], 1'b1);
    cmp("b01_stop_last", cap_tx[80], 1'b1);
    cmp("b01_busy_last", cap_busy[80], 1'b1);
    cmp("b01_busy_after", cap_busy[81], 1'b0);
    wait_idle();
    cmp("b01_rx_byte", rx_byte, 8'h01);

    // Glitch on rx: two low cycles then high.
    loop_en = 1'b0;
    d_done  = n_done;
    d_ferr  = n_ferr;
    rx_drv  = 1'b0;
    repeat (2) @(negedge clk);
    rx_drv = 1'b1;
    repeat (30) @(negedge clk);
    cmp("glitch_no_done", n_done - d_done, 0);
    cmp("glitch_no_ferr", n_ferr - d_ferr, 0);
    send_rx(8'h5A, 1'b1);
    wait_idle();
    cmp("glitch_then_good", rx_byte, 8'h5A);

    // Framing error, line held low 40 cycles, then a good 0xC3.
    d_done = n_done;
    d_ferr = n_ferr;
    send_rx(8'h3C, 1'b0);
    repeat (40) @(negedge clk);
    rx_drv = 1'b1;
    wait_idle();
    cmp("ferr_count", n_ferr - d_ferr, 1);
    cmp("ferr_no_done", n_done - d_done, 0);
    cmp("ferr_byte_held", rx_byte, 8'h5A);
    send_rx(8'hC3, 1'b1);
    wait_idle();
    cmp("after_ferr_byte", rx_byte, 8'hC3);
    cmp("after_ferr_done", n_done - d_done, 1);

    // Busy guard: second request 10 cycles into the frame is dropped.
    loop_en = 1'b1;
    d_done  = n_done;
    pulse_go(8'h55);
    repeat (9) @(negedge clk);
    pulse_go(8'hFF);
    wait_idle();
    cmp("guard_done_count", n_done - d_done, 1);
    cmp("guard_rx_byte", rx_byte, 8'h55);

    // Reset in the middle of a frame.
    d_done = n_done;
    pulse_go(8'h96);
    repeat (30) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    cmp("midrst_tx", tx, 1'b1);
    cmp("midrst_busy", tx_busy, 1'b0);
    cmp("midrst_rx_byte", rx_byte, 8'h00);
    repeat (3) @(negedge clk);
    pulse_go(8'h00);
    wait_idle();
    cmp("midrst_no_stale_done", n_done - d_done, 1);
    cmp("midrst_fresh_byte", rx_byte, 8'h00);

    // Randomised traffic: loopback frames, back-to-back driven frames, occasional framing errors.
    for (int it = 0; it < 16; it++) begin
      case ($urandom_range(0, 2))
        0: begin
          loop_en = 1'b1;
          repeat ($urandom_range(0, 5)) @(negedge clk);
          pulse_go(8'($urandom));
          wait_idle();
        end
        1: begin
          loop_en = 1'b0;
          for (int j = 0; j < int'($urandom_range(1, 3)); j++) send_rx(8'($urandom), 1'b1);
          wait_idle();
        end
        default: begin
          loop_en = 1'b0;
          send_rx(8'($urandom), 1'b0);
          repeat ($urandom_range(0, 20)) @(negedge clk);
          rx_drv = 1'b1;
          wait_idle();
        end
      endcase
    end

    // tx_go held high: frames repeat with one idle cycle between them,
    // and tx_data changes mid-frame must not leak into the frame in flight.
    loop_en = 1'b1;
    d_done  = n_done;
    tx_data = 8'($urandom);
    tx_go   = 1'b1;
    for (int k = 0; k < 3 * (FRAME_CYC + 1) - 5; k++) begin
      if ($urandom_range(0, 7) == 0) tx_data = 8'($urandom);
      @(negedge clk);
    end
    tx_go = 1'b0;
    wait_idle();
    cmp("held_go_frames", n_done - d_done, 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
